// File: rtl/axi_ram_arbiter_if.sv
// Bundles the two master ports and the shared RAM port of the arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface axi_ram_arbiter_if;
  logic [31:0] m0_awaddr, m0_wdata, m0_araddr, m0_rdata;
  logic [7:0]  m0_awlen, m0_arlen;
  logic        m0_awvalid, m0_awready, m0_wlast, m0_wvalid, m0_wready;
  logic        m0_bvalid, m0_bready, m0_arvalid, m0_arready, m0_rvalid, m0_rready;

  logic [31:0] m1_awaddr, m1_wdata, m1_araddr, m1_rdata;
  logic [7:0]  m1_awlen, m1_arlen;
  logic        m1_awvalid, m1_awready, m1_wlast, m1_wvalid, m1_wready;
  logic        m1_bvalid, m1_bready, m1_arvalid, m1_arready, m1_rvalid, m1_rready;

  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [7:0]  s_awlen, s_arlen;
  logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;

  modport slave (
    input  m0_awaddr, m0_awlen, m0_awvalid, m0_wdata, m0_wlast, m0_wvalid, m0_bready,
           m0_araddr, m0_arlen, m0_arvalid, m0_rready,
    output m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rdata, m0_rvalid,
    input  m1_awaddr, m1_awlen, m1_awvalid, m1_wdata, m1_wlast, m1_wvalid, m1_bready,
           m1_araddr, m1_arlen, m1_arvalid, m1_rready,
    output m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rdata, m1_rvalid,
    output s_awaddr, s_awlen, s_awvalid, s_wdata, s_wlast, s_wvalid, s_bready,
           s_araddr, s_arlen, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bvalid, s_arready, s_rdata, s_rvalid
  );

  modport master (
    output m0_awaddr, m0_awlen, m0_awvalid, m0_wdata, m0_wlast, m0_wvalid, m0_bready,
           m0_araddr, m0_arlen, m0_arvalid, m0_rready,
    input  m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rdata, m0_rvalid,
    output m1_awaddr, m1_awlen, m1_awvalid, m1_wdata, m1_wlast, m1_wvalid, m1_bready,
           m1_araddr, m1_arlen, m1_arvalid, m1_rready,
    input  m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rdata, m1_rvalid,
    input  s_awaddr, s_awlen, s_awvalid, s_wdata, s_wlast, s_wvalid, s_bready,
           s_araddr, s_arlen, s_arvalid, s_rready,
    output s_awready, s_wready, s_bvalid, s_arready, s_rdata, s_rvalid
  );
endinterface

// File: rtl/axi_ram_arbiter.sv
// Two-master arbiter onto a single AXI-like RAM port; one burst in flight at a time.
// Round-robin or fixed priority between masters, write before read within a master.
module axi_ram_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic              clk,
    input  logic              reset,
    axi_ram_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, ADDR, READ, WRITE_DATA, WRITE_RESP} state_t;

    state_t      state, state_nxt;
    logic        grant, is_write, last_grant;
    logic [31:0] addr;
    logic [7:0]  count;

    logic        req0, req1, pick, pick_write, grant_now;
    logic [31:0] pick_addr;
    logic [7:0]  pick_len;
    logic        g_wvalid, g_rready, g_bready;
    logic [31:0] g_wdata;
    logic        rbeat, wbeat;

    always_comb begin
        req0 = bus.m0_awvalid || bus.m0_arvalid;
        req1 = bus.m1_awvalid || bus.m1_arvalid;
        if (req0 && req1) pick = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
        else              pick = req1;
        // Gated by reset so no ready pulse escapes while reset is held.
        grant_now  = (state == IDLE) && (req0 || req1) && !reset;
        pick_write = pick ? bus.m1_awvalid : bus.m0_awvalid;
        case ({pick, pick_write})
            2'b00:   begin pick_addr = bus.m0_araddr; pick_len = bus.m0_arlen; end
            2'b01:   begin pick_addr = bus.m0_awaddr; pick_len = bus.m0_awlen; end
            2'b10:   begin pick_addr = bus.m1_araddr; pick_len = bus.m1_arlen; end
            default: begin pick_addr = bus.m1_awaddr; pick_len = bus.m1_awlen; end
        endcase
        if (pick_len == '0) pick_len = 8'd1;
        g_wvalid = grant ? bus.m1_wvalid : bus.m0_wvalid;
        g_wdata  = grant ? bus.m1_wdata  : bus.m0_wdata;
        g_rready = grant ? bus.m1_rready : bus.m0_rready;
        g_bready = grant ? bus.m1_bready : bus.m0_bready;
        rbeat    = (state == READ) && bus.s_rvalid && g_rready;
        wbeat    = (state == WRITE_DATA) && g_wvalid && bus.s_wready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            is_write   <= 1'b0;
            addr       <= '0;
            count      <= '0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (grant_now) begin
                grant    <= pick;
                is_write <= pick_write;
                addr     <= pick_addr;
                count    <= pick_len;
            end
            if (rbeat || wbeat) count <= count - 8'd1;
            if (state != IDLE && state_nxt == IDLE) last_grant <= grant;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (grant_now) state_nxt = ADDR;
            ADDR: begin
                if (is_write && bus.s_awready)       state_nxt = WRITE_DATA;
                else if (!is_write && bus.s_arready) state_nxt = READ;
            end
            READ:       if (rbeat && count == 8'd1) state_nxt = IDLE;
            WRITE_DATA: if (wbeat && count == 8'd1) state_nxt = WRITE_RESP;
            WRITE_RESP: if (bus.s_bvalid && g_bready) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.m0_awready = 1'b0; bus.m0_wready = 1'b0; bus.m0_bvalid = 1'b0;
        bus.m0_arready = 1'b0; bus.m0_rvalid = 1'b0;
        bus.m1_awready = 1'b0; bus.m1_wready = 1'b0; bus.m1_bvalid = 1'b0;
        bus.m1_arready = 1'b0; bus.m1_rvalid = 1'b0;
        bus.m0_rdata   = bus.s_rdata;
        bus.m1_rdata   = bus.s_rdata;
        bus.s_awaddr   = addr;
        bus.s_awlen    = count;
        bus.s_araddr   = addr;
        bus.s_arlen    = count;
        bus.s_wdata    = g_wdata;
        bus.s_awvalid  = 1'b0;
        bus.s_arvalid  = 1'b0;
        bus.s_wvalid   = 1'b0;
        bus.s_wlast    = 1'b0;
        bus.s_bready   = 1'b0;
        bus.s_rready   = 1'b0;
        case (state)
            IDLE: if (grant_now) begin
                if (!pick) begin
                    bus.m0_awready = pick_write;
                    bus.m0_arready = !pick_write;
                end else begin
                    bus.m1_awready = pick_write;
                    bus.m1_arready = !pick_write;
                end
            end
            ADDR: begin
                bus.s_awvalid = is_write;
                bus.s_arvalid = !is_write;
            end
            READ: begin
                bus.s_rready = g_rready;
                if (grant) bus.m1_rvalid = bus.s_rvalid;
                else       bus.m0_rvalid = bus.s_rvalid;
            end
            WRITE_DATA: begin
                bus.s_wvalid = g_wvalid;
                bus.s_wlast  = (count == 8'd1);
                if (grant) bus.m1_wready = bus.s_wready;
                else       bus.m0_wready = bus.s_wready;
            end
            WRITE_RESP: begin
                bus.s_bready = g_bready;
                if (grant) bus.m1_bvalid = bus.s_bvalid;
                else       bus.m0_bvalid = bus.s_bvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_ram_arbiter.sv
// Directed self-checking bench: a round-robin instance (rb) and a fixed-priority instance (fb).
module tb_axi_ram_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    axi_ram_arbiter_if rb();
    axi_ram_arbiter_if fb();

    axi_ram_arbiter #(.ROUND_ROBIN(1)) dut_rr (.clk(clk), .reset(reset), .bus(rb.slave));
    axi_ram_arbiter #(.ROUND_ROBIN(0)) dut_fp (.clk(clk), .reset(reset), .bus(fb.slave));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        rb.m0_awaddr = '0; rb.m0_awlen = '0; rb.m0_awvalid = 0; rb.m0_wdata = '0; rb.m0_wlast = 0;
        rb.m0_wvalid = 0; rb.m0_bready = 0; rb.m0_araddr = '0; rb.m0_arlen = '0; rb.m0_arvalid = 0;
        rb.m0_rready = 0;
        rb.m1_awaddr = '0; rb.m1_awlen = '0; rb.m1_awvalid = 0; rb.m1_wdata = '0; rb.m1_wlast = 0;
        rb.m1_wvalid = 0; rb.m1_bready = 0; rb.m1_araddr = '0; rb.m1_arlen = '0; rb.m1_arvalid = 0;
        rb.m1_rready = 0;
        rb.s_awready = 0; rb.s_wready = 0; rb.s_bvalid = 0; rb.s_arready = 0; rb.s_rdata = '0;
        rb.s_rvalid = 0;
        fb.m0_awaddr = '0; fb.m0_awlen = '0; fb.m0_awvalid = 0; fb.m0_wdata = '0; fb.m0_wlast = 0;
        fb.m0_wvalid = 0; fb.m0_bready = 0; fb.m0_araddr = '0; fb.m0_arlen = '0; fb.m0_arvalid = 0;
        fb.m0_rready = 0;
        fb.m1_awaddr = '0; fb.m1_awlen = '0; fb.m1_awvalid = 0; fb.m1_wdata = '0; fb.m1_wlast = 0;
        fb.m1_wvalid = 0; fb.m1_bready = 0; fb.m1_araddr = '0; fb.m1_arlen = '0; fb.m1_arvalid = 0;
        fb.m1_rready = 0;
        fb.s_awready = 0; fb.s_wready = 0; fb.s_bvalid = 0; fb.s_arready = 0; fb.s_rdata = '0;
        fb.s_rvalid = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rb.m0_arvalid = 1; rb.m0_araddr = 32'h44;
        step(); step();
        checks++;
        if (rb.m0_arready !== 1'b0 || rb.m1_arready !== 1'b0 || rb.m0_awready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got m0_ar=%0b m1_ar=%0b m0_aw=%0b want 0 0 0",
                     rb.m0_arready, rb.m1_arready, rb.m0_awready);
        end
        checks++;
        if ({rb.s_awvalid, rb.s_arvalid, rb.s_wvalid, rb.s_bready, rb.s_rready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_s_valid got %05b want 00000",
                     {rb.s_awvalid, rb.s_arvalid, rb.s_wvalid, rb.s_bready, rb.s_rready});
        end
        checks++;
        if (rb.s_araddr !== 32'h0 || rb.s_arlen !== 8'h0) begin
            errors++;
            $display("FAIL reset_addr got addr=%h len=%0d want 0 0", rb.s_araddr, rb.s_arlen);
        end
        rb.m0_arvalid = 0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        rb.m0_araddr = 32'h100; rb.m0_arlen = 8'd4; rb.m0_arvalid = 1;
        #1;
        checks++;
        if (rb.m0_arready !== 1'b1 || rb.m1_arready !== 1'b0) begin
            errors++;
            $display("FAIL rd_arready got m0=%0b m1=%0b want 1 0", rb.m0_arready, rb.m1_arready);
        end
        step();
        rb.m0_arvalid = 0;
        #1;
        checks++;
        if (rb.m0_arready !== 1'b0 || rb.s_arvalid !== 1'b1 || rb.s_araddr !== 32'h100 || rb.s_arlen !== 8'd4) begin
            errors++;
            $display("FAIL rd_addr got pulse=%0b v=%0b a=%h l=%0d want 0 1 100 4",
                     rb.m0_arready, rb.s_arvalid, rb.s_araddr, rb.s_arlen);
        end
        rb.s_arready = 1;
        step();
        rb.s_arready = 0;
        rb.m0_rready = 1;
        for (int k = 0; k < 4; k++) begin
            rb.s_rvalid = 1; rb.s_rdata = 32'hA000 + k;
            #1;
            checks++;
            if (rb.m0_rvalid !== 1'b1 || rb.m1_rvalid !== 1'b0 || rb.s_rready !== 1'b1 ||
                rb.m0_rdata !== (32'hA000 + k) || rb.s_arvalid !== 1'b0) begin
                errors++;
                $display("FAIL rd_beat%0d got m0v=%0b m1v=%0b rr=%0b d=%h arv=%0b want 1 0 1 %h 0",
                         k, rb.m0_rvalid, rb.m1_rvalid, rb.s_rready, rb.m0_rdata, rb.s_arvalid, 32'hA000 + k);
            end
            step();
        end
        #1;
        checks++;
        if (rb.m0_rvalid !== 1'b0 || rb.s_rready !== 1'b0) begin
            errors++;
            $display("FAIL rd_end got m0v=%0b rr=%0b want 0 0", rb.m0_rvalid, rb.s_rready);
        end
        rb.s_rvalid = 0; rb.m0_rready = 0;
        step();
    endtask

    task automatic test_round_robin();
        reset = 1; step(); reset = 0; step();
        rb.m0_araddr = 32'h200; rb.m0_arlen = 8'd1; rb.m0_rready = 1;
        rb.m1_araddr = 32'h300; rb.m1_arlen = 8'd1; rb.m1_rready = 1;
        rb.m0_arvalid = 1; rb.m1_arvalid = 1;
        for (int i = 0; i < 4; i++) begin
            logic want1;
            want1 = (i % 2) == 1;
            #1;
            checks++;
            if (rb.m0_arready !== !want1 || rb.m1_arready !== want1) begin
                errors++;
                $display("FAIL rr_grant%0d got m0=%0b m1=%0b want %0b %0b",
                         i, rb.m0_arready, rb.m1_arready, !want1, want1);
            end
            step();
            checks++;
            if (rb.s_araddr !== (want1 ? 32'h300 : 32'h200) || rb.s_arvalid !== 1'b1) begin
                errors++;
                $display("FAIL rr_addr%0d got a=%h v=%0b want %h 1",
                         i, rb.s_araddr, rb.s_arvalid, want1 ? 32'h300 : 32'h200);
            end
            rb.s_arready = 1;
            step();
            rb.s_arready = 0; rb.s_rvalid = 1;
            step();
            rb.s_rvalid = 0;
        end
        rb.m0_arvalid = 0; rb.m1_arvalid = 0; rb.m0_rready = 0; rb.m1_rready = 0;
        step();
    endtask

    task automatic test_fixed_priority();
        fb.m0_araddr = 32'h200; fb.m0_arlen = 8'd1; fb.m0_rready = 1;
        fb.m1_araddr = 32'h300; fb.m1_arlen = 8'd1; fb.m1_rready = 1;
        fb.m0_arvalid = 1; fb.m1_arvalid = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (fb.m0_arready !== 1'b1 || fb.m1_arready !== 1'b0) begin
                errors++;
                $display("FAIL fp_grant%0d got m0=%0b m1=%0b want 1 0", i, fb.m0_arready, fb.m1_arready);
            end
            step();
            fb.s_arready = 1;
            step();
            fb.s_arready = 0; fb.s_rvalid = 1;
            #1;
            checks++;
            if (fb.m0_rvalid !== 1'b1 || fb.m1_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL fp_beat%0d got m0v=%0b m1v=%0b want 1 0", i, fb.m0_rvalid, fb.m1_rvalid);
            end
            step();
            fb.s_rvalid = 0;
        end
        fb.m0_arvalid = 0; fb.m1_arvalid = 0; fb.m0_rready = 0; fb.m1_rready = 0;
        step();
    endtask

    task automatic test_write_wready_toggle();
        logic [4:0] pat;
        int beats;
        pat = 5'b10101;
        beats = 0;
        rb.m1_awaddr = 32'h400; rb.m1_awlen = 8'd3; rb.m1_awvalid = 1;
        #1;
        checks++;
        if (rb.m1_awready !== 1'b1 || rb.m0_awready !== 1'b0 || rb.m1_arready !== 1'b0) begin
            errors++;
            $display("FAIL wr_awready got m1=%0b m0=%0b m1ar=%0b want 1 0 0",
                     rb.m1_awready, rb.m0_awready, rb.m1_arready);
        end
        step();
        rb.m1_awvalid = 0;
        #1;
        checks++;
        if (rb.s_awvalid !== 1'b1 || rb.s_awaddr !== 32'h400 || rb.s_awlen !== 8'd3 || rb.s_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_addr got v=%0b a=%h l=%0d arv=%0b want 1 400 3 0",
                     rb.s_awvalid, rb.s_awaddr, rb.s_awlen, rb.s_arvalid);
        end
        rb.s_awready = 1;
        step();
        rb.s_awready = 0;
        rb.m1_wvalid = 1; rb.m1_wlast = 0; rb.m1_bready = 1;
        for (int j = 0; j < 5; j++) begin
            rb.s_wready = pat[4 - j];
            rb.m1_wdata = 32'hD0 + beats;
            #1;
            checks++;
            if (rb.s_wvalid !== 1'b1 || rb.m1_wready !== pat[4 - j] || rb.m0_wready !== 1'b0 ||
                rb.s_wdata !== (32'hD0 + beats) || rb.s_wlast !== (beats == 2)) begin
                errors++;
                $display("FAIL wr_cyc%0d got wv=%0b m1wr=%0b m0wr=%0b d=%h last=%0b want 1 %0b 0 %h %0b",
                         j, rb.s_wvalid, rb.m1_wready, rb.m0_wready, rb.s_wdata, rb.s_wlast,
                         pat[4 - j], 32'hD0 + beats, beats == 2);
            end
            if (pat[4 - j]) beats++;
            step();
        end
        rb.s_wready = 0;
        #1;
        checks++;
        if (rb.s_wvalid !== 1'b0 || rb.m1_bvalid !== 1'b0 || rb.s_bready !== 1'b1) begin
            errors++;
            $display("FAIL wr_resp_wait got wv=%0b bv=%0b br=%0b want 0 0 1",
                     rb.s_wvalid, rb.m1_bvalid, rb.s_bready);
        end
        step();
        rb.s_bvalid = 1;
        #1;
        checks++;
        if (rb.m1_bvalid !== 1'b1 || rb.m0_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_bvalid got m1=%0b m0=%0b want 1 0", rb.m1_bvalid, rb.m0_bvalid);
        end
        step();
        rb.s_bvalid = 0;
        #1;
        checks++;
        if (rb.m1_bvalid !== 1'b0 || rb.s_bready !== 1'b0) begin
            errors++;
            $display("FAIL wr_done got bv=%0b br=%0b want 0 0", rb.m1_bvalid, rb.s_bready);
        end
        rb.m1_wvalid = 0; rb.m1_bready = 0;
        step();
    endtask

    task automatic test_write_before_read();
        rb.m0_awaddr = 32'h500; rb.m0_awlen = 8'd1; rb.m0_awvalid = 1;
        rb.m0_araddr = 32'h600; rb.m0_arlen = 8'd2; rb.m0_arvalid = 1;
        #1;
        checks++;
        if (rb.m0_awready !== 1'b1 || rb.m0_arready !== 1'b0) begin
            errors++;
            $display("FAIL wbr_first got aw=%0b ar=%0b want 1 0", rb.m0_awready, rb.m0_arready);
        end
        step();
        rb.m0_awvalid = 0;
        #1;
        checks++;
        if (rb.s_awvalid !== 1'b1 || rb.s_arvalid !== 1'b0 || rb.s_awaddr !== 32'h500) begin
            errors++;
            $display("FAIL wbr_addr got awv=%0b arv=%0b a=%h want 1 0 500",
                     rb.s_awvalid, rb.s_arvalid, rb.s_awaddr);
        end
        rb.s_awready = 1;
        step();
        rb.s_awready = 0; rb.m0_wvalid = 1; rb.s_wready = 1; rb.m0_bready = 1;
        #1;
        checks++;
        if (rb.s_wlast !== 1'b1 || rb.m0_wready !== 1'b1) begin
            errors++;
            $display("FAIL wbr_wlast got last=%0b wr=%0b want 1 1", rb.s_wlast, rb.m0_wready);
        end
        step();
        rb.m0_wvalid = 0; rb.s_wready = 0; rb.s_bvalid = 1;
        step();
        rb.s_bvalid = 0; rb.m0_bready = 0;
        #1;
        checks++;
        if (rb.m0_arready !== 1'b1 || rb.m0_awready !== 1'b0) begin
            errors++;
            $display("FAIL wbr_second got ar=%0b aw=%0b want 1 0", rb.m0_arready, rb.m0_awready);
        end
        step();
        rb.m0_arvalid = 0;
        #1;
        checks++;
        if (rb.s_arvalid !== 1'b1 || rb.s_araddr !== 32'h600 || rb.s_arlen !== 8'd2) begin
            errors++;
            $display("FAIL wbr_rdaddr got v=%0b a=%h l=%0d want 1 600 2",
                     rb.s_arvalid, rb.s_araddr, rb.s_arlen);
        end
        rb.s_arready = 1;
        step();
        rb.s_arready = 0; rb.s_rvalid = 1; rb.m0_rready = 1;
        step(); step();
        rb.s_rvalid = 0; rb.m0_rready = 0;
        step();
    endtask

    task automatic test_reset_mid_burst();
        rb.m0_araddr = 32'h700; rb.m0_arlen = 8'd8; rb.m0_arvalid = 1;
        step();
        rb.m0_arvalid = 0; rb.s_arready = 1;
        step();
        rb.s_arready = 0; rb.s_rvalid = 1; rb.m0_rready = 1;
        step();
        #1;
        reset = 1;
        step();
        checks++;
        if (rb.m0_rvalid !== 1'b0 || rb.s_rready !== 1'b0 || rb.s_arvalid !== 1'b0 || rb.m1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got m0v=%0b rr=%0b arv=%0b m1v=%0b want 0 0 0 0",
                     rb.m0_rvalid, rb.s_rready, rb.s_arvalid, rb.m1_rvalid);
        end
        rb.s_rvalid = 0; rb.m0_rready = 0;
        reset = 0;
        step();
        rb.m1_araddr = 32'h800; rb.m1_arlen = 8'd0; rb.m1_arvalid = 1; rb.m1_rready = 1;
        #1;
        checks++;
        if (rb.m1_arready !== 1'b1) begin
            errors++;
            $display("FAIL rst_regrant got %0b want 1", rb.m1_arready);
        end
        step();
        rb.m1_arvalid = 0;
        #1;
        checks++;
        if (rb.s_arlen !== 8'd1 || rb.s_araddr !== 32'h800 || rb.s_arvalid !== 1'b1) begin
            errors++;
            $display("FAIL len0 got l=%0d a=%h v=%0b want 1 800 1", rb.s_arlen, rb.s_araddr, rb.s_arvalid);
        end
        rb.s_arready = 1;
        step();
        rb.s_arready = 0; rb.s_rvalid = 1;
        step();
        rb.s_rvalid = 0;
        #1;
        checks++;
        if (rb.m1_rvalid !== 1'b0 || rb.s_rready !== 1'b0) begin
            errors++;
            $display("FAIL len0_end got m1v=%0b rr=%0b want 0 0", rb.m1_rvalid, rb.s_rready);
        end
        rb.m1_rready = 0;
        step();
    endtask

    initial begin
        init_inputs();
        #2;
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_write_wready_toggle();
        test_write_before_read();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end
endmodule
